// File: rtl/output_port_arbiter.sv
// ---------------------------------------------------------------------------
// output_port_arbiter
//
// Round-robin arbiter that merges NUM_IN packet streams into one output link
// through a single-entry output register.
//
// Ports:
//   clk        - single clock, all state changes on the rising edge
//   rst        - asynchronous, active-high reset
//   in_valid   - per-input "packet offered" flags
//   in_data    - packed input packets, input i at [i*WIDTH_packet +: WIDTH_packet]
//   in_ready   - one-hot (or zero) "packet taken this cycle" per input
//   out_valid  - output register holds a packet
//   out_data   - held packet
//   out_ready  - downstream accepts out_data this cycle
//   grant_id   - source index of the held packet
//   pkt_count  - number of packets delivered downstream (wraps)
// ---------------------------------------------------------------------------
module output_port_arbiter #(
  parameter int NUM_IN       = 4,
  parameter int WIDTH_packet = 14,
  parameter int CNT_W        = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_IN-1:0]              in_valid,
  input  logic [NUM_IN*WIDTH_packet-1:0] in_data,
  output logic [NUM_IN-1:0]              in_ready,
  output logic                           out_valid,
  output logic [WIDTH_packet-1:0]        out_data,
  input  logic                           out_ready,
  output logic [$clog2(NUM_IN)-1:0]      grant_id,
  output logic [CNT_W-1:0]               pkt_count
);

  localparam int IDX_W = $clog2(NUM_IN);
  // NUM_IN at the width of the scan arithmetic (one extra bit absorbs the
  // rr_ptr + offset overflow before the modulo fold).
  localparam logic [IDX_W:0] NUM_IN_W = NUM_IN[IDX_W:0];

  logic                    out_valid_q, out_valid_d;
  logic [WIDTH_packet-1:0] out_data_q,  out_data_d;
  logic [IDX_W-1:0]        grant_id_q,  grant_id_d;
  logic [IDX_W-1:0]        rr_ptr_q,    rr_ptr_d;
  logic [CNT_W-1:0]        pkt_count_q, pkt_count_d;

  logic                    can_accept_s;
  logic                    found_s;
  logic [IDX_W-1:0]        win_idx_s;
  logic [IDX_W:0]          scan_sum_s;
  logic [IDX_W:0]          next_ptr_s;
  logic [NUM_IN-1:0]       in_ready_s;
  logic                    transfer_s;
  logic                    delivery_s;

  // Round-robin scan: first requester at rr_ptr, rr_ptr+1, ... mod NUM_IN.
  always_comb begin
    found_s    = 1'b0;
    win_idx_s  = '0;
    scan_sum_s = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      scan_sum_s = {1'b0, rr_ptr_q} + k[IDX_W:0];
      if (scan_sum_s >= NUM_IN_W) begin
        scan_sum_s = scan_sum_s - NUM_IN_W;
      end else begin
        scan_sum_s = scan_sum_s;
      end
      if (!found_s && in_valid[scan_sum_s[IDX_W-1:0]]) begin
        found_s   = 1'b1;
        win_idx_s = scan_sum_s[IDX_W-1:0];
      end else begin
        found_s   = found_s;
      end
    end
  end

  // Handshake decode. in_ready is gated by rst so it is zero while reset is
  // held, even though the (cleared) output register could accept.
  always_comb begin
    can_accept_s = !out_valid_q || out_ready;
    in_ready_s   = '0;
    if (!rst && can_accept_s && found_s) begin
      in_ready_s[win_idx_s] = 1'b1;
    end else begin
      in_ready_s = '0;
    end
    transfer_s = |in_ready_s;
    delivery_s = out_valid_q && out_ready;
  end

  // Next-state for the output register, round-robin pointer and counter.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    pkt_count_d = pkt_count_q;
    next_ptr_s  = {1'b0, win_idx_s} + {{IDX_W{1'b0}}, 1'b1};

    if (transfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(win_idx_s)*WIDTH_packet +: WIDTH_packet];
      grant_id_d  = win_idx_s;
      if (next_ptr_s >= NUM_IN_W) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = next_ptr_s[IDX_W-1:0];
      end
    end else if (delivery_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (delivery_s) begin
      pkt_count_d = pkt_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      pkt_count_d = pkt_count_q;
    end
  end

  // State registers; reset discards any held packet without counting it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      pkt_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant_id  = grant_id_q;
  assign pkt_count = pkt_count_q;

endmodule
